// File: rtl/hazard_pkg.sv
// Shared types and constants for the EX-stage forwarding and hazard control block.
package hazard_pkg;

   localparam int unsigned REG_ADDR_W = 5;

   localparam logic [1:0] FWD_REG = 2'b00;
   localparam logic [1:0] FWD_WB  = 2'b01;
   localparam logic [1:0] FWD_MEM = 2'b10;

   typedef logic [REG_ADDR_W-1:0] reg_addr_t;

   typedef struct packed {
      reg_addr_t rd;
      logic      regwrite;
      logic      memread;
   } stage_info_t;

endpackage

// File: rtl/hazard_forward_ctrl_if.sv
// ID-stage inputs and pipeline control outputs of the forwarding/hazard controller.
interface hazard_forward_ctrl_if
   import hazard_pkg::*;
#(
   parameter int unsigned CNT_W = 16
);

   reg_addr_t        id_rs1_i;
   reg_addr_t        id_rs2_i;
   reg_addr_t        id_rd_i;
   logic             id_regwrite_i;
   logic             id_memread_i;
   logic             branch_taken_i;
   logic [1:0]       fwd_a_o;
   logic [1:0]       fwd_b_o;
   logic             pc_write_o;
   logic             ifid_write_o;
   logic             idex_bubble_o;
   logic             ifid_flush_o;
   logic [CNT_W-1:0] stall_count_o;

   // Pipeline side: presents the ID instruction and consumes the controls.
   modport master (
      output id_rs1_i, id_rs2_i, id_rd_i, id_regwrite_i, id_memread_i, branch_taken_i,
      input  fwd_a_o, fwd_b_o, pc_write_o, ifid_write_o, idex_bubble_o, ifid_flush_o,
             stall_count_o
   );

   modport slave (
      input  id_rs1_i, id_rs2_i, id_rd_i, id_regwrite_i, id_memread_i, branch_taken_i,
      output fwd_a_o, fwd_b_o, pc_write_o, ifid_write_o, idex_bubble_o, ifid_flush_o,
             stall_count_o
   );

endinterface

// File: rtl/hazard_forward_ctrl_fwd_select.sv
// Priority compare for one EX operand: the younger MEM result beats the older WB result.
module fwd_select
   import hazard_pkg::*;
(
   input  reg_addr_t  ex_rs,
   input  reg_addr_t  mem_rd,
   input  logic       mem_regwrite,
   input  reg_addr_t  wb_rd,
   input  logic       wb_regwrite,
   output logic [1:0] sel
);

   always_comb begin
      sel = FWD_REG;
      if (mem_regwrite && (mem_rd != '0) && (mem_rd == ex_rs)) begin
         sel = FWD_MEM;
      end else if (wb_regwrite && (wb_rd != '0) && (wb_rd == ex_rs)) begin
         sel = FWD_WB;
      end
   end

endmodule

// File: rtl/hazard_forward_ctrl.sv
// EX operand forwarding selects, load-use stall/bubble, branch flush gating and a
// saturating stall-cycle counter, all driven from shadow copies of the pipeline state.
module hazard_forward_ctrl
   import hazard_pkg::*;
#(
   parameter int unsigned CNT_W = 16
) (
   input logic                  clk_i,
   input logic                  rst_i,
   hazard_forward_ctrl_if.slave bus
);

   stage_info_t      ex_q, ex_d;
   reg_addr_t        ex_rs1_q, ex_rs2_q;
   reg_addr_t        mem_rd_q, wb_rd_q;
   logic             mem_rw_q, wb_rw_q;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             hz;

   always_comb begin
      hz = ex_q.memread && (ex_q.rd != '0) &&
           ((ex_q.rd == bus.id_rs1_i) || (ex_q.rd == bus.id_rs2_i));
   end

   always_comb begin
      ex_d = '{rd: bus.id_rd_i, regwrite: bus.id_regwrite_i, memread: bus.id_memread_i};
      // The bubble drops memread, which is what limits the stall to one cycle.
      if (hz) begin
         ex_d = '0;
      end
      cnt_d = cnt_q;
      if (hz && (cnt_q != '1)) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         ex_q     <= '0;
         ex_rs1_q <= '0;
         ex_rs2_q <= '0;
         mem_rd_q <= '0;
         mem_rw_q <= 1'b0;
         wb_rd_q  <= '0;
         wb_rw_q  <= 1'b0;
         cnt_q    <= '0;
      end else begin
         ex_q     <= ex_d;
         ex_rs1_q <= bus.id_rs1_i;
         ex_rs2_q <= bus.id_rs2_i;
         mem_rd_q <= ex_q.rd;
         mem_rw_q <= ex_q.regwrite;
         wb_rd_q  <= mem_rd_q;
         wb_rw_q  <= mem_rw_q;
         cnt_q    <= cnt_d;
      end
   end

   fwd_select u_fwd_a (
      .ex_rs        (ex_rs1_q),
      .mem_rd       (mem_rd_q),
      .mem_regwrite (mem_rw_q),
      .wb_rd        (wb_rd_q),
      .wb_regwrite  (wb_rw_q),
      .sel          (bus.fwd_a_o)
   );

   fwd_select u_fwd_b (
      .ex_rs        (ex_rs2_q),
      .mem_rd       (mem_rd_q),
      .mem_regwrite (mem_rw_q),
      .wb_rd        (wb_rd_q),
      .wb_regwrite  (wb_rw_q),
      .sel          (bus.fwd_b_o)
   );

   // A stall holds the branch in ID, so its flush is taken on the retry instead.
   assign bus.pc_write_o    = !hz;
   assign bus.ifid_write_o  = !hz;
   assign bus.idex_bubble_o = hz;
   assign bus.ifid_flush_o  = bus.branch_taken_i && !hz;
   assign bus.stall_count_o = cnt_q;

endmodule
